// File: rtl/mult_div_unit.sv
// Multi-cycle signed/unsigned multiply (shift-add) and restoring divide with HI/LO result registers.
// Latency WIDTH+1 cycles busy then a 1-cycle done; starts are dropped while busy, no backpressure.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic             mult_sign,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] op_mag;
  logic [WIDTH-1:0] a_raw;
  logic             is_div;
  logic             res_neg;
  logic             rem_neg;
  logic             b_zero;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic             rem_fit;
  logic             last;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] fix_hi;
  logic [WIDTH-1:0] fix_lo;

  always_comb begin
    a_neg   = mult_sign & src_a[WIDTH-1];
    b_neg   = mult_sign & src_b[WIDTH-1];
    a_mag   = a_neg ? (WIDTH'(0) - src_a) : src_a;
    b_mag   = b_neg ? (WIDTH'(0) - src_b) : src_b;
    // Multiply: acc_lo holds the remaining multiplier bits, acc_hi the running upper half.
    mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, op_mag} : {(WIDTH+1){1'b0}});
    // Divide: acc_lo shifts the dividend out and the quotient in.
    rem_sh  = {acc_hi, acc_lo[WIDTH-1]};
    diff    = rem_sh - {1'b0, op_mag};
    rem_fit = ~diff[WIDTH];
    last    = (cnt == CNT_W'(WIDTH - 1));
    prod     = {acc_hi, acc_lo};
    prod_fix = res_neg ? ((2*WIDTH)'(0) - prod) : prod;
    fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
    fix_lo   = prod_fix[WIDTH-1:0];
    if (is_div) begin
      if (b_zero) begin
        fix_hi = a_raw;
        fix_lo = {WIDTH{1'b1}};
      end else begin
        fix_hi = rem_neg ? (WIDTH'(0) - acc_hi) : acc_hi;
        fix_lo = res_neg ? (WIDTH'(0) - acc_lo) : acc_lo;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      op_mag      <= '0;
      a_raw       <= '0;
      is_div      <= 1'b0;
      res_neg     <= 1'b0;
      rem_neg     <= 1'b0;
      b_zero      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (hi_we) hi <= wr_data;
          if (lo_we) lo <= wr_data;
          if (start_mult || start_div) begin
            state       <= start_mult ? S_MUL : S_DIV;
            is_div      <= ~start_mult;
            busy        <= 1'b1;
            cnt         <= '0;
            div_by_zero <= 1'b0;
            a_raw       <= src_a;
            res_neg     <= a_neg ^ b_neg;
            rem_neg     <= a_neg;
            b_zero      <= (src_b == '0);
            acc_hi      <= '0;
            op_mag      <= start_mult ? a_mag : b_mag;
            acc_lo      <= start_mult ? b_mag : a_mag;
          end
        end
        S_MUL: begin
          {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
          cnt <= cnt + CNT_W'(1);
          if (last) state <= S_FIX;
        end
        S_DIV: begin
          acc_hi <= rem_fit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
          acc_lo <= {acc_lo[WIDTH-2:0], rem_fit};
          cnt    <= cnt + CNT_W'(1);
          if (last) begin
            state       <= S_FIX;
            div_by_zero <= b_zero;
          end
        end
        default: begin
          hi    <= fix_hi;
          lo    <= fix_lo;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed plus seeded-random scoreboard bench for mult_div_unit at WIDTH 32 and WIDTH 8.
// Starts are single-cycle pulses; results are matched against a queue when done fires.
module tb_mult_div_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start_mult, start_div, mult_sign, hi_we, lo_we;
  logic [31:0] src_a, src_b, wr_data;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  logic        start_mult_8, start_div_8, mult_sign_8, hi_we_8, lo_we_8;
  logic [7:0]  src_a_8, src_b_8, wr_data_8;
  logic        busy_8, done_8, div_by_zero_8;
  logic [7:0]  hi_8, lo_8;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start_mult(start_mult), .start_div(start_div),
    .mult_sign(mult_sign), .src_a(src_a), .src_b(src_b), .hi_we(hi_we), .lo_we(lo_we),
    .wr_data(wr_data), .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  mult_div_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start_mult(start_mult_8), .start_div(start_div_8),
    .mult_sign(mult_sign_8), .src_a(src_a_8), .src_b(src_b_8), .hi_we(hi_we_8), .lo_we(lo_we_8),
    .wr_data(wr_data_8), .busy(busy_8), .done(done_8), .div_by_zero(div_by_zero_8),
    .hi(hi_8), .lo(lo_8)
  );

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input string tag, input logic m, input logic d, input logic s,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el, input logic ez,
                       input logic inject);
    int   busy_cyc;
    int   guard;
    int   extra;
    exp_t e;
    busy_cyc = 0;
    guard    = 0;
    extra    = 0;
    @(negedge clk);
    start_mult = m;
    start_div  = d;
    mult_sign  = s;
    src_a      = a;
    src_b      = b;
    sb_q.push_back('{hi: eh, lo: el, dbz: ez});
    @(negedge clk);
    start_mult = 1'b0;
    start_div  = 1'b0;
    src_a      = $urandom;
    src_b      = $urandom;
    mult_sign  = ~s;
    chk({tag, "/dbz_clear"}, 64'(div_by_zero), 64'(0));
    while (!done && guard < 200) begin
      if (busy) busy_cyc++;
      if (inject) begin
        start_div = (busy_cyc == 5);
        hi_we     = (busy_cyc == 5);
        wr_data   = 32'hDEAD;
      end
      @(negedge clk);
      guard++;
    end
    start_div = 1'b0;
    hi_we     = 1'b0;
    chk({tag, "/done_seen"}, 64'(done), 64'(1));
    e = '0;
    if (sb_q.size() > 0) e = sb_q.pop_front();
    chk({tag, "/hi"}, 64'(hi), 64'(e.hi));
    chk({tag, "/lo"}, 64'(lo), 64'(e.lo));
    chk({tag, "/dbz"}, 64'(div_by_zero), 64'(e.dbz));
    chk({tag, "/busy_at_done"}, 64'(busy), 64'(0));
    chk({tag, "/busy_cycles"}, 64'(busy_cyc), 64'(33));
    @(negedge clk);
    chk({tag, "/done_pulse"}, 64'(done), 64'(0));
    if (inject) begin
      repeat (40) begin
        @(negedge clk);
        if (done) extra++;
      end
      chk({tag, "/no_second_done"}, 64'(extra), 64'(0));
      chk({tag, "/hi_kept"}, 64'(hi), 64'(eh));
    end
  endtask

  initial begin
    logic [31:0]        ra, rb;
    logic signed [31:0] sa, sb;
    logic [63:0]        p;
    int                 busy_cyc, guard, extra;

    reset = 1'b0;
    {start_mult, start_div, mult_sign, hi_we, lo_we} = '0;
    src_a = '0; src_b = '0; wr_data = '0;
    {start_mult_8, start_div_8, mult_sign_8, hi_we_8, lo_we_8} = '0;
    src_a_8 = '0; src_b_8 = '0; wr_data_8 = '0;

    repeat (2) @(negedge clk);
    chk("reset/hi", 64'(hi), 64'(0));
    chk("reset/lo", 64'(lo), 64'(0));
    chk("reset/busy", 64'(busy), 64'(0));
    chk("reset/done", 64'(done), 64'(0));
    chk("reset/dbz", 64'(div_by_zero), 64'(0));
    start_mult = 1'b1; src_a = 32'h5; src_b = 32'h5;
    @(negedge clk);
    start_mult = 1'b0;
    @(negedge clk);
    chk("reset_held/busy", 64'(busy), 64'(0));
    chk("reset_held/lo", 64'(lo), 64'(0));
    reset = 1'b1;
    @(negedge clk);
    chk("idle/busy", 64'(busy), 64'(0));

    do_op("umul_max", 1, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0, 0);
    do_op("smul_neg", 1, 0, 1, 32'hFFFF_FFF9, 32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 0, 0);
    do_op("sdiv_neg", 0, 1, 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 0);
    do_op("udiv", 0, 1, 0, 32'd100, 32'd7, 32'd2, 32'd14, 0, 0);
    do_op("sdiv_ovf", 0, 1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 0, 0);
    do_op("div_zero", 0, 1, 0, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1, 0);
    do_op("sdiv_zero", 0, 1, 1, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1, 0);
    do_op("both_start", 1, 1, 0, 32'd3, 32'd4, 32'd0, 32'd12, 0, 0);

    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 28);
      sa = ra;
      sb = rb;
      case (i % 4)
        0: begin
          p = {32'h0, ra} * {32'h0, rb};
          do_op("rnd_umul", 1, 0, 0, ra, rb, p[63:32], p[31:0], 0, 0);
        end
        1: begin
          p = $signed({{32{ra[31]}}, ra}) * $signed({{32{rb[31]}}, rb});
          do_op("rnd_smul", 1, 0, 1, ra, rb, p[63:32], p[31:0], 0, 0);
        end
        2: begin
          if (rb == 0) rb = 32'd3;
          do_op("rnd_udiv", 0, 1, 0, ra, rb, ra % rb, ra / rb, 0, 0);
        end
        default: begin
          if (sb == 0 || sb == -1) sb = -32'sd5;
          do_op("rnd_sdiv", 0, 1, 1, sa, sb, 32'(sa % sb), 32'(sa / sb), 0, 0);
        end
      endcase
    end

    do_op("busy_ignore", 1, 0, 0, 32'd2, 32'd3, 32'd0, 32'd6, 0, 1);

    @(negedge clk);
    hi_we = 1'b1; wr_data = 32'h1234;
    @(negedge clk);
    hi_we = 1'b0;
    chk("hi_we/hi", 64'(hi), 64'h1234);
    chk("hi_we/lo", 64'(lo), 64'd6);
    lo_we = 1'b1; wr_data = 32'h55;
    @(negedge clk);
    lo_we = 1'b0;
    chk("lo_we/lo", 64'(lo), 64'h55);
    chk("lo_we/hi", 64'(hi), 64'h1234);

    start_mult_8 = 1'b1; src_a_8 = 8'hFF; src_b_8 = 8'hFF;
    @(negedge clk);
    start_mult_8 = 1'b0;
    busy_cyc = 0;
    guard    = 0;
    while (!done_8 && guard < 100) begin
      if (busy_8) busy_cyc++;
      @(negedge clk);
      guard++;
    end
    chk("w8/done_seen", 64'(done_8), 64'(1));
    chk("w8/hi", 64'(hi_8), 64'hFE);
    chk("w8/lo", 64'(lo_8), 64'h01);
    chk("w8/busy_cycles", 64'(busy_cyc), 64'(9));

    @(negedge clk);
    start_mult = 1'b1; mult_sign = 1'b0; src_a = 32'd9; src_b = 32'd9;
    @(negedge clk);
    start_mult = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort/busy_before", 64'(busy), 64'(1));
    reset = 1'b0;
    #1;
    chk("abort/hi", 64'(hi), 64'(0));
    chk("abort/lo", 64'(lo), 64'(0));
    chk("abort/busy", 64'(busy), 64'(0));
    chk("abort/done", 64'(done), 64'(0));
    @(negedge clk);
    reset = 1'b1;
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) extra++;
    end
    chk("abort/no_done", 64'(extra), 64'(0));
    chk("abort/lo_after", 64'(lo), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
